alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU between two requesters: port 0 is the pipeline EX stage, port 1 is a multicycle helper such as the mul/div or address unit.
- Arbitration is weighted round-robin.
- Each requester uses a valid/ready request handshake and gets a registered, backpressurable response.
- The ALU-side ports map 1:1 onto the alu_if tb modport, with alu_if's alu modport connected to the ALU.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - weighted round-robin arbiter sharing one 32-bit ALU between two requesters
// Optional feature macro: ALU_ARB_LOCK_EN (adds req0_lock/req1_lock exclusive-ownership inputs).
module alu_arbiter #(
    parameter int P0_WEIGHT = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic        req0_lock,
    input  logic        req1_lock,
`endif
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_o,
    output logic [2:0]  rsp_nzv,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_o,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] WEIGHT  = 4'(P0_WEIGHT);

    logic       last_grant;
    logic [3:0] streak;
    logic       slot_free;
    logic       p0_pref;
    logic       gnt0;
    logic       gnt1;
    logic       wrr_update;

`ifdef ALU_ARB_LOCK_EN
    logic       lock_active;
    logic       lock_owner;
`endif

    // A slot held by a response being consumed this cycle can be refilled on the same edge.
    assign slot_free = (!rsp0_valid && !rsp1_valid)
                     || (rsp0_valid && rsp0_ready)
                     || (rsp1_valid && rsp1_ready);
    assign p0_pref   = last_grant || (streak < WEIGHT);

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        wrr_update = 1'b1;
`ifdef ALU_ARB_LOCK_EN
        wrr_update = !lock_active;
`endif
        if (nRST && slot_free) begin
`ifdef ALU_ARB_LOCK_EN
            if (lock_active) begin
                gnt0 = !lock_owner && req0_valid;
                gnt1 = lock_owner && req1_valid;
            end else
`endif
            if (req0_valid && req1_valid) begin
                gnt0 = p0_pref;
                gnt1 = !p0_pref;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = ALU_ADD;
        if (gnt0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_o      <= 32'd0;
            rsp_nzv    <= 3'd0;
            last_grant <= 1'b1;
            streak     <= 4'd0;
        end else begin
            if (gnt0 || gnt1) begin
                rsp_o      <= alu_o;
                rsp_nzv    <= {alu_n, alu_z, alu_v};
                rsp0_valid <= gnt0;
                rsp1_valid <= gnt1;
            end else begin
                if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
                if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;
            end

            if (gnt0 && wrr_update) begin
                streak     <= last_grant ? 4'd1 : ((streak == 4'd15) ? 4'd15 : streak + 4'd1);
                last_grant <= 1'b0;
            end else if (gnt1 && wrr_update) begin
                streak     <= 4'd0;
                last_grant <= 1'b1;
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // An accept with lock=0 from the owner releases ownership on that same edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (gnt0) begin
            lock_active <= req0_lock;
            lock_owner  <= 1'b0;
        end else if (gnt1) begin
            lock_active <= req1_lock;
            lock_owner  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        req0_lock, req1_lock;
    logic        rsp0_ready, rsp1_ready;

    logic        r0_rdy1, r1_rdy1, v0_1, v1_1;
    logic [31:0] rsp_o1, alu_a1, alu_b1, alu_o1;
    logic [2:0]  nzv1;
    logic [3:0]  alu_op1;
    logic        alu_n1, alu_z1, alu_v1;

    logic        r0_rdy3, r1_rdy3, v0_3, v1_3;
    logic [31:0] rsp_o3, alu_a3, alu_b3, alu_o3;
    logic [2:0]  nzv3;
    logic [3:0]  alu_op3;
    logic        alu_n3, alu_z3, alu_v3;

    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            AND: r = a & b;
            OR:  r = a | b;
            XOR: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), v, r};
    endfunction

    assign {alu_n1, alu_z1, alu_v1, alu_o1} = alu_fn(alu_a1, alu_b1, alu_op1);
    assign {alu_n3, alu_z3, alu_v3, alu_o3} = alu_fn(alu_a3, alu_b3, alu_op3);

    alu_arbiter #(.P0_WEIGHT(1)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(req0_valid), .req0_ready(r0_rdy1), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r1_rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .rsp0_valid(v0_1), .rsp0_ready(rsp0_ready), .rsp1_valid(v1_1), .rsp1_ready(rsp1_ready),
        .rsp_o(rsp_o1), .rsp_nzv(nzv1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_o(alu_o1), .alu_n(alu_n1), .alu_z(alu_z1), .alu_v(alu_v1)
    );

    alu_arbiter #(.P0_WEIGHT(3)) dut3 (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(req0_valid), .req0_ready(r0_rdy3), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r1_rdy3), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .rsp0_valid(v0_3), .rsp0_ready(rsp0_ready), .rsp1_valid(v1_3), .rsp1_ready(rsp1_ready),
        .rsp_o(rsp_o3), .rsp_nzv(nzv3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_o(alu_o3), .alu_n(alu_n3), .alu_z(alu_z3), .alu_v(alu_v3)
    );

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0;
        logic [3:0]  op0;
        logic [31:0] a1, b1;
        logic [3:0]  op1;
        logic        rr0, rr1;
        logic        er0, er1;
        logic        ev0, ev1;
        logic [31:0] eo;
        logic [2:0]  enzv;
    } vec_t;

    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = ADD;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = ADD;
        req0_lock = 1'b0; req1_lock = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd3, SUB, 32'd0, 32'd0, ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 3'b000};
        vecs[1] = '{1'b1, 1'b0, 32'd3, 32'd5, SUB, 32'd0, 32'd0, ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 3'b100};
        vecs[2] = '{1'b0, 1'b1, 32'd0, 32'd0, ADD, 32'd7, 32'hF0, AND, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 3'b010};
        vecs[3] = '{1'b1, 1'b1, 32'd1, 32'd2, OR, 32'd9, 32'd9, ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 3'b000};
        vecs[4] = '{1'b1, 1'b1, 32'd1, 32'd2, OR, 32'h8000_0000, 32'd1, SUB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b001};
        vecs[5] = '{1'b1, 1'b1, 32'd1, 32'd2, OR, 32'd4, 32'd4, XOR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b001};
        vecs[6] = '{1'b0, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 32'd0, ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 3'b001};
        vecs[7] = '{1'b1, 1'b1, 32'hFF, 32'hFF, XOR, 32'd2, 32'd3, ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 3'b010};
        vecs[8] = '{1'b0, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 32'd0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 3'b010};
        vecs[9] = '{1'b0, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 32'd0, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b010};

        // Reset state, with a request pending while reset is held.
        nRST = 1'b0;
        idle_inputs();
        req0_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_req0_ready", {31'd0, r0_rdy1}, 32'd0);
        check("reset_rsp0_valid", {31'd0, v0_1}, 32'd0);
        check("reset_rsp1_valid", {31'd0, v1_1}, 32'd0);
        check("reset_rsp_o", rsp_o1, 32'd0);
        check("reset_rsp_nzv", {29'd0, nzv1}, 32'd0);
        check("reset_alu_op", {28'd0, alu_op1}, {28'd0, ADD});
        @(negedge CLK);
        nRST = 1'b1;
        req0_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_op = vecs[i].op0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_op = vecs[i].op1;
            rsp0_ready = vecs[i].rr0; rsp1_ready = vecs[i].rr1;
            #1;
            check($sformatf("vec%0d_req0_ready", i), {31'd0, r0_rdy1}, {31'd0, vecs[i].er0});
            check($sformatf("vec%0d_req1_ready", i), {31'd0, r1_rdy1}, {31'd0, vecs[i].er1});
            if (!vecs[i].er0 && !vecs[i].er1) begin
                check($sformatf("vec%0d_idle_alu_a", i), alu_a1, 32'd0);
                check($sformatf("vec%0d_idle_alu_b", i), alu_b1, 32'd0);
            end
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_rsp0_valid", i), {31'd0, v0_1}, {31'd0, vecs[i].ev0});
            check($sformatf("vec%0d_rsp1_valid", i), {31'd0, v1_1}, {31'd0, vecs[i].ev1});
            check($sformatf("vec%0d_rsp_o", i), rsp_o1, vecs[i].eo);
            check($sformatf("vec%0d_rsp_nzv", i), {29'd0, nzv1}, {29'd0, vecs[i].enzv});
        end

        // Both valid continuously: weight 1 alternates, weight 3 gives three port-0 grants per port-1 grant.
        do_reset();
        begin
            logic [7:0] pat1, pat3;
            pat1 = 8'b1010_1010;
            pat3 = 8'b1000_1000;
            for (int i = 0; i < 8; i++) begin
                @(negedge CLK);
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_a = 32'(i); req1_a = 32'(i + 100);
                rsp0_ready = 1'b1; rsp1_ready = 1'b1;
                #1;
                check($sformatf("wrr1_cycle%0d_grant1", i), {31'd0, r1_rdy1}, {31'd0, pat1[i]});
                check($sformatf("wrr1_cycle%0d_grant0", i), {31'd0, r0_rdy1}, {31'd0, ~pat1[i]});
                check($sformatf("wrr3_cycle%0d_grant1", i), {31'd0, r1_rdy3}, {31'd0, pat3[i]});
                check($sformatf("wrr3_cycle%0d_grant0", i), {31'd0, r0_rdy3}, {31'd0, ~pat3[i]});
            end
        end

        // Backpressure on port 1 with a signed-overflow result held for four cycles.
        do_reset();
        @(negedge CLK);
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_op = ADD;
        #1;
        check("bp_accept_req1_ready", {31'd0, r1_rdy1}, 32'd1);
        @(negedge CLK);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = ADD;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d_req0_ready", i), {31'd0, r0_rdy1}, 32'd0);
            check($sformatf("bp%0d_rsp1_valid", i), {31'd0, v1_1}, 32'd1);
            check($sformatf("bp%0d_rsp_o", i), rsp_o1, 32'h8000_0000);
            check($sformatf("bp%0d_rsp_nzv", i), {29'd0, nzv1}, 32'd5);
            @(negedge CLK);
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp_drain_req0_ready", {31'd0, r0_rdy1}, 32'd1);
        check("bp_drain_req1_ready", {31'd0, r1_rdy1}, 32'd0);
        @(posedge CLK);
        #1;
        check("bp_after_rsp0_valid", {31'd0, v0_1}, 32'd1);
        check("bp_after_rsp1_valid", {31'd0, v1_1}, 32'd0);
        check("bp_after_rsp_o", rsp_o1, 32'd30);

        // Asynchronous reset while port 0 holds a response; without reset port 1 would win next.
        do_reset();
        @(negedge CLK);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ADD;
        @(posedge CLK);
        #1;
        check("rst_mid_rsp0_valid_before", {31'd0, v0_1}, 32'd1);
        req1_valid = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        check("rst_mid_rsp0_valid_async", {31'd0, v0_1}, 32'd0);
        check("rst_mid_req0_ready_low", {31'd0, r0_rdy1}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check("rst_mid_first_grant0", {31'd0, r0_rdy1}, 32'd1);
        check("rst_mid_first_grant1", {31'd0, r1_rdy1}, 32'd0);

`ifdef ALU_ARB_LOCK_EN
        // Port 1 locks for three ops (lock 1,1,0); port 0 is held off until the release edge.
        do_reset();
        begin
            logic [3:0] e0, e1, lk, v0;
            v0 = 4'b1110; lk = 4'b0011; e1 = 4'b0111; e0 = 4'b1000;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                rsp0_ready = 1'b1; rsp1_ready = 1'b1;
                req0_valid = v0[i];
                req1_valid = (i < 3);
                req1_lock  = lk[i];
                req1_a = 32'(i); req1_b = 32'd1; req1_op = ADD;
                #1;
                check($sformatf("lock%0d_req0_ready", i), {31'd0, r0_rdy1}, {31'd0, e0[i]});
                check($sformatf("lock%0d_req1_ready", i), {31'd0, r1_rdy1}, {31'd0, e1[i]});
            end
        end
`endif

        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
